stream_result_checker: RTL and testbench

- Self-checking scoreboard stage; drives the pass/fail inputs of the bench status/reporting block.
- Compares a DUT output stream against an expected-value stream buffered in an internal FIFO.
- Raises sticky pass after NUM_WORDS consecutive matches, or sticky fail on mismatch, idle timeout, or unexpected extra data.
- Synthesizable, so it runs both in simulation and in the FPGA test harness.

---
 rtl/stream_result_checker.sv | 192 +++++++++++++++++++
 tb/tb_stream_result_checker.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_result_checker.sv
// Scoreboard stage: checks a DUT output stream against buffered expected words.
// Sticky pass after NUM_WORDS matches; sticky fail on mismatch, timeout or extra data.
module stream_result_checker #(
  parameter int DATA_W     = 32,
  parameter int EXP_DEPTH  = 8,
  parameter int NUM_WORDS  = 16,
  parameter int IDLE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic [DATA_W-1:0] act_data,
  output logic              pass,
  output logic              fail,
  output logic              done,
  output logic [1:0]        fail_code,
  output logic [15:0]       word_count,
  output logic [15:0]       err_index,
  output logic [DATA_W-1:0] err_expected,
  output logic [DATA_W-1:0] err_actual
);

  localparam int AW = $clog2(EXP_DEPTH);
  localparam int IW = $clog2(IDLE_LIMIT + 1);
  localparam logic [15:0]   NW = 16'(NUM_WORDS);
  localparam logic [IW-1:0] IL = IW'(IDLE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL
  } state_t;

  state_t state_q;

  logic [DATA_W-1:0] mem_q [EXP_DEPTH];
  logic [AW:0]       wr_q, wr_d;
  logic [AW:0]       rd_q, rd_d;
  logic [AW-1:0]     wr_addr;
  logic              empty, full;
  logic              push, pop, flush;
  logic [DATA_W-1:0] head;
  logic              match;

  logic [15:0]       word_q, word_nxt;
  logic [IW-1:0]     idle_q, idle_nxt;
  logic              pass_q, fail_q;
  logic [1:0]        code_q;
  logic [15:0]       eidx_q;
  logic [DATA_W-1:0] eexp_q, eact_q;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign exp_ready = !full;
  assign act_ready = (state_q == S_RUN) && !empty;

  assign push  = exp_valid && !full;
  assign pop   = act_valid && act_ready;
  assign flush = start &&
                 ((state_q == S_PASS) || (state_q == S_FAIL));

  assign head     = mem_q[rd_q[AW-1:0]];
  assign word_nxt = word_q + 16'd1;
  assign idle_nxt = idle_q + IW'(1);

  // A push that coincides with a flush lands in the emptied FIFO.
  always_comb begin
    wr_addr = flush ? '0 : wr_q[AW-1:0];
    wr_d    = flush ? {{AW{1'b0}}, push}
                    : wr_q + {{AW{1'b0}}, push};
    rd_d    = flush ? '0
                    : rd_q + {{AW{1'b0}}, pop};
  end

  // X/Z on the actual word must read as a mismatch in simulation.
  always_comb begin
`ifdef SYNTHESIS
    match = (act_data == head);
`else
    match = (act_data === head);
`endif
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_addr] <= exp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      idle_q  <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= 2'd0;
      eidx_q  <= '0;
      eexp_q  <= '0;
      eact_q  <= '0;
    end else if (flush) begin
      state_q <= S_RUN;
      word_q  <= '0;
      idle_q  <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= 2'd0;
      eidx_q  <= '0;
      eexp_q  <= '0;
      eact_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            word_q  <= '0;
            idle_q  <= '0;
          end
        end
        S_RUN: begin
          if (pop) begin
            idle_q <= '0;
            if (match) begin
              if (word_q != NW) begin
                word_q <= word_nxt;
              end
              if (word_nxt == NW) begin
                state_q <= S_PASS;
                pass_q  <= 1'b1;
              end
            end else begin
              state_q <= S_FAIL;
              fail_q  <= 1'b1;
              code_q  <= 2'd1;
              eidx_q  <= word_q;
              eexp_q  <= head;
              eact_q  <= act_data;
            end
          end else begin
            idle_q <= idle_nxt;
            if (idle_nxt == IL) begin
              state_q <= S_FAIL;
              fail_q  <= 1'b1;
              code_q  <= 2'd2;
              eidx_q  <= word_q;
            end
          end
        end
        S_PASS: begin
          if (act_valid) begin
            state_q <= S_FAIL;
            pass_q  <= 1'b0;
            fail_q  <= 1'b1;
            code_q  <= 2'd3;
            eidx_q  <= NW;
          end
        end
        S_FAIL: begin
          state_q <= S_FAIL;
        end
      endcase
    end
  end

  assign pass         = pass_q;
  assign fail         = fail_q;
  assign done         = pass_q | fail_q;
  assign fail_code    = code_q;
  assign word_count   = word_q;
  assign err_index    = eidx_q;
  assign err_expected = eexp_q;
  assign err_actual   = eact_q;

endmodule

// File: tb/tb_stream_result_checker.sv
// Randomized bench for stream_result_checker against a queue-based model.
// Every cycle all outputs are compared with the model; directed checks follow the test plan.
module tb_stream_result_checker;

  localparam int DATA_W     = 32;
  localparam int EXP_DEPTH  = 8;
  localparam int NUM_WORDS  = 16;
  localparam int IDLE_LIMIT = 64;

  logic              clk;
  logic              reset;
  logic              start;
  logic              exp_valid;
  logic              exp_ready;
  logic [DATA_W-1:0] exp_data;
  logic              act_valid;
  logic              act_ready;
  logic [DATA_W-1:0] act_data;
  logic              pass;
  logic              fail;
  logic              done;
  logic [1:0]        fail_code;
  logic [15:0]       word_count;
  logic [15:0]       err_index;
  logic [DATA_W-1:0] err_expected;
  logic [DATA_W-1:0] err_actual;

  stream_result_checker #(
    .DATA_W    (DATA_W),
    .EXP_DEPTH (EXP_DEPTH),
    .NUM_WORDS (NUM_WORDS),
    .IDLE_LIMIT(IDLE_LIMIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .exp_valid   (exp_valid),
    .exp_ready   (exp_ready),
    .exp_data    (exp_data),
    .act_valid   (act_valid),
    .act_ready   (act_ready),
    .act_data    (act_data),
    .pass        (pass),
    .fail        (fail),
    .done        (done),
    .fail_code   (fail_code),
    .word_count  (word_count),
    .err_index   (err_index),
    .err_expected(err_expected),
    .err_actual  (err_actual)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  logic [DATA_W-1:0] m_q[$];
  bit                m_run, m_pass, m_fail;
  int                m_wc, m_idle, m_code, m_eidx;
  logic [DATA_W-1:0] m_eexp, m_eact;
  bit                m_push, m_pop;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_run  = 0;
    m_pass = 0;
    m_fail = 0;
    m_wc   = 0;
    m_idle = 0;
    m_code = 0;
    m_eidx = 0;
    m_eexp = '0;
    m_eact = '0;
  endtask

  task automatic model_update();
    bit                erdy, ardy, restart;
    logic [DATA_W-1:0] head;
    erdy   = m_q.size() < EXP_DEPTH;
    ardy   = m_run && (m_q.size() > 0);
    m_push = exp_valid && erdy;
    m_pop  = act_valid && ardy;
    if (reset) begin
      m_q.delete();
      model_clear();
      m_push = 0;
      m_pop  = 0;
      return;
    end
    head    = (m_q.size() > 0) ? m_q[0] : '0;
    restart = start && (m_pass || m_fail);
    if (restart) m_q.delete();
    else if (m_pop) void'(m_q.pop_front());
    if (m_push) m_q.push_back(exp_data);
    if (restart) begin
      model_clear();
      m_run = 1;
    end else if (start && !m_run && !m_pass && !m_fail) begin
      m_run  = 1;
      m_wc   = 0;
      m_idle = 0;
    end else if (m_run) begin
      if (m_pop) begin
        m_idle = 0;
        if (act_data == head) begin
          m_wc++;
          if (m_wc == NUM_WORDS) begin
            m_run  = 0;
            m_pass = 1;
          end
        end else begin
          m_run  = 0;
          m_fail = 1;
          m_code = 1;
          m_eidx = m_wc;
          m_eexp = head;
          m_eact = act_data;
        end
      end else begin
        m_idle++;
        if (m_idle == IDLE_LIMIT) begin
          m_run  = 0;
          m_fail = 1;
          m_code = 2;
          m_eidx = m_wc;
        end
      end
    end else if (m_pass && act_valid) begin
      m_pass = 0;
      m_fail = 1;
      m_code = 3;
      m_eidx = NUM_WORDS;
    end
  endtask

  task automatic check_all();
    chk("exp_ready", exp_ready, m_q.size() < EXP_DEPTH);
    chk("act_ready", act_ready, m_run && (m_q.size() > 0));
    chk("pass", pass, m_pass);
    chk("fail", fail, m_fail);
    chk("done", done, m_pass || m_fail);
    chk("fail_code", fail_code, m_code);
    chk("word_count", word_count, m_wc);
    chk("err_index", err_index, m_eidx);
    chk("err_expected", err_expected, m_eexp);
    chk("err_actual", err_actual, m_eact);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #2;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic stream(input logic [DATA_W-1:0] base, input int n,
                        input int bad, input logic [DATA_W-1:0] badv,
                        input int pv, input bit preload,
                        input int stop_at);
    int pi  = 0;
    int ai  = 0;
    int cyc = 0;
    if (preload) begin
      while (pi < n && m_q.size() < EXP_DEPTH && cyc < 100) begin
        exp_valid = 1;
        exp_data  = base + pi;
        tick();
        if (m_push) pi++;
        cyc++;
      end
      exp_valid = 0;
    end
    pulse_start();
    cyc = 0;
    while (!(m_pass || m_fail) && ai < stop_at && cyc < 3000) begin
      exp_valid = (pi < n) && ($urandom_range(99) < pv);
      exp_data  = base + pi;
      act_valid = (ai < n) && ($urandom_range(99) < pv);
      act_data  = (ai == bad) ? badv : base + ai;
      tick();
      if (m_push) pi++;
      if (m_pop) ai++;
      cyc++;
    end
    exp_valid = 0;
    act_valid = 0;
    chk("stream_bound", cyc < 3000, 1);
  endtask

  initial begin
    int ai, n;
    reset     = 1;
    start     = 0;
    exp_valid = 0;
    exp_data  = '0;
    act_valid = 0;
    act_data  = '0;
    m_q.delete();
    model_clear();
    tick();
    tick();
    chk("rst_exp_ready", exp_ready, 1);
    chk("rst_done", done, 0);
    reset = 0;
    tick();

    // full matching stream from preload
    stream(32'h100, 16, -1, '0, 100, 1, 17);
    chk("tp1_pass", pass, 1);
    chk("tp1_fail", fail, 0);
    chk("tp1_wc", word_count, 16);
    chk("tp1_code", fail_code, 0);

    // extra data after pass
    act_valid = 1;
    act_data  = 32'h5;
    tick();
    act_valid = 0;
    chk("xtra_pass", pass, 0);
    chk("xtra_code", fail_code, 3);
    chk("xtra_idx", err_index, 16);

    // mismatch at 6th word, restart from FAIL
    stream(32'h100, 16, 5, 32'h1FF, 100, 0, 17);
    chk("mm_code", fail_code, 1);
    chk("mm_idx", err_index, 5);
    chk("mm_exp", err_expected, 32'h105);
    chk("mm_act", err_actual, 32'h1FF);
    chk("mm_pass", pass, 0);

    // idle timeout after two matches
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_valid = 1;
      exp_data  = 32'h200 + i;
      tick();
    end
    exp_valid = 0;
    pulse_start();
    ai = 0;
    n  = 0;
    while (ai < 2 && n < 20) begin
      act_valid = 1;
      act_data  = 32'h200 + ai;
      tick();
      if (m_pop) ai++;
      n++;
    end
    act_valid = 0;
    n = 0;
    while (!fail && n < 100) begin
      tick();
      n++;
    end
    chk("tmo_lat", n, 64);
    chk("tmo_code", fail_code, 2);
    chk("tmo_idx", err_index, 2);

    // fill, then push+pop while full
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk("fill_rdy", exp_ready, 1);
      exp_valid = 1;
      exp_data  = 32'h300 + i;
      tick();
    end
    exp_valid = 0;
    chk("full_rdy", exp_ready, 0);
    pulse_start();
    exp_valid = 1;
    exp_data  = 32'h308;
    act_valid = 1;
    act_data  = 32'h300;
    tick();
    exp_valid = 0;
    act_valid = 0;
    chk("pp_rdy", exp_ready, 1);
    chk("pp_occ", m_q.size(), 7);

    // reset mid-run after 10 matches
    do_reset();
    stream(32'h400, 16, -1, '0, 100, 1, 10);
    chk("mid_wc", word_count, 10);
    do_reset();
    chk("mid_act_ready", act_ready, 0);
    chk("mid_exp_ready", exp_ready, 1);
    chk("mid_wc0", word_count, 0);
    chk("mid_done", done, 0);
    stream(32'h500, 16, -1, '0, 70, 1, 17);
    chk("mid_pass", pass, 1);

    // randomized runs restarted from PASS/FAIL
    for (int r = 0; r < 12; r++) begin
      int bad;
      bad = ($urandom_range(2) == 0) ? -1 : int'($urandom_range(15));
      stream($urandom, 16, bad, $urandom, 40 + $urandom_range(60), 0, 17);
      chk("rnd_done", done, 1);
      if (pass && $urandom_range(1) == 1) begin
        act_valid = 1;
        act_data  = $urandom;
        tick();
        act_valid = 0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
